// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row sync, per-scan ghost rejection, debounce FSM.
// Optional auto-repeat on held keys when KEYSCAN_REPEAT_EN is defined.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_event
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_L = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_L  = CW'(DEBOUNCE_SCANS - 1);

  generate
    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
      $error("keypad_scanner: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

  logic [3:0]    row_meta, row_sync;
  logic [DW-1:0] div;
  logic [1:0]    col;
  logic [1:0]    acc_hits, hits_n;
  logic [3:0]    acc_cand, cand_n;
  logic [2:0]    smp_hits, tot_hits;
  logic [1:0]    smp_row;
  logic [3:0]    smp_code;
  logic          tick, scan_done, scan_single, hold_match, accept, rpt_fire;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    cand_r;

  assign tick      = (div == DIV_L);
  assign scan_done = tick && (col == 2'd3);

  // Per-column sample: count low rows, keep the lowest row index.
  always_comb begin
    smp_hits = 3'd0;
    smp_row  = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync[r]) begin
        smp_hits = smp_hits + 3'd1;
        smp_row  = 2'(r);
      end
    end
    smp_code = {smp_row, col};
    tot_hits = {1'b0, acc_hits} + smp_hits;
    hits_n   = (tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0];
    cand_n   = (smp_hits != 3'd0 && smp_code < acc_cand) ? smp_code : acc_cand;
  end

  // Multi-key scans fall out as "not single" and so behave like no key.
  assign scan_single = (hits_n == 2'd1);
  assign hold_match  = scan_single && (cand_n == key_code);
  assign accept      = (state == IDLE) ? (DEBOUNCE_SCANS == 1)
                                       : (cand_n == cand_r && cnt == DB_L);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
      div      <= '0;
      col      <= 2'd0;
      col_n    <= 4'b1110;
      acc_hits <= 2'd0;
      acc_cand <= 4'hF;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
      div      <= tick ? '0 : div + 1'b1;
      if (tick) begin
        col   <= col + 2'd1;
        col_n <= {col_n[2:0], col_n[3]};
        if (col == 2'd3) begin
          acc_hits <= 2'd0;
          acc_cand <= 4'hF;
        end else begin
          acc_hits <= hits_n;
          acc_cand <= cand_n;
        end
      end
    end
  end

`ifdef KEYSCAN_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] RD_L = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_L = RW'(REPEAT_RATE - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_first;

  assign rpt_fire = scan_done && (state == HELD) && hold_match &&
                    (rpt_cnt == (rpt_first ? RR_L : RD_L));

  // Count only scans that stay in HELD; a bounce through DB_RELEASE pauses it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else if (state != HELD && state != DB_RELEASE) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (scan_done && state == HELD && hold_match) begin
      rpt_cnt   <= rpt_cnt + 1'b1;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cand_r    <= 4'h0;
      key_code  <= 4'hF;
      key_valid <= 1'b0;
      key_event <= 1'b0;
    end else begin
      key_event <= rpt_fire;
      if (scan_done) begin
        unique case (state)
          IDLE, DB_PRESS: begin
            if (!scan_single) begin
              state <= IDLE;
            end else if (accept) begin
              key_code  <= cand_n;
              key_valid <= 1'b1;
              key_event <= 1'b1;
              state     <= HELD;
            end else if (state == DB_PRESS && cand_n == cand_r) begin
              cnt <= cnt + 1'b1;
            end else begin
              cand_r <= cand_n;
              cnt    <= CW'(1);
              state  <= DB_PRESS;
            end
          end
          HELD: begin
            if (!hold_match) begin
              if (DEBOUNCE_SCANS == 1) begin
                key_valid <= 1'b0;
                state     <= IDLE;
              end else begin
                cnt   <= CW'(1);
                state <= DB_RELEASE;
              end
            end
          end
          DB_RELEASE: begin
            if (hold_match) begin
              state <= HELD;
            end else if (cnt == DB_L) begin
              key_valid <= 1'b0;
              state     <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
